fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage plus F/D pipeline latch, directly upstream of the decode stage.
- Owns the PC register and drives the synchronous instruction ROM (1-cycle read latency).
- Presents instruction, PC and PC+1 to decode through the F/D latch.
- Handles decode/hazard stalls, taken-branch/jump redirects, and counts retired-to-decode instructions and flushes.

Parameters:
- ADDR_WIDTH, 12, imem address width; imem_addr = low ADDR_WIDTH bits of the selected PC.
- RESET_PC, 32'd0, PC value loaded on reset.
- NOP, 32'd0, bubble instruction inserted on flush/reset (opcode 00000, regALU with all-zero regs).

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  hold PC and F/D latch (load-use hazard, multicycle unit busy).
- flush  in  1  redirect fetch to redirect_pc (taken bne/blt/bex, j, jal, jr resolved downstream).
- redirect_pc  in  32  target PC, valid when flush=1.
- imem_addr  out  ADDR_WIDTH  ROM address, combinational.
- imem_data  in  32  ROM output; registered inside the ROM, so it reflects imem_addr of the previous cycle.
- fd_instruction  out  32  F/D latched instruction to decode.
- fd_pc  out  32  PC of fd_instruction.
- fd_pc_plus1  out  32  fd_pc+1, used by jal to write $31.
- fd_valid  out  1  1 = fd_instruction is a real fetched instruction; 0 = bubble.
- fetch_count  out  32  number of instructions loaded into F/D.
- flush_count  out  16  number of flush events accepted.

Behaviour:
- Registers: pc (32), fd_instruction, fd_pc, fd_pc_plus1, fd_valid, fetch_count, flush_count.
- Invariant: in any cycle with reset=0, imem_data = mem[pc]. The address mux keeps the ROM one step ahead of pc to hold this.
- imem_addr mux, combinational, priority order:
  - reset: RESET_PC.
  - flush: redirect_pc.
  - stall: pc.
  - otherwise: pc+1.
  - In every case imem_addr takes the low ADDR_WIDTH bits.
- Rising-edge update, priority order (reset > flush > stall > advance):
  - reset: pc<=RESET_PC; fd_instruction<=NOP; fd_pc<=0; fd_pc_plus1<=0; fd_valid<=0; fetch_count<=0; flush_count<=0.
  - flush: pc<=redirect_pc; fd_instruction<=NOP; fd_valid<=0; fd_pc/fd_pc_plus1 hold; flush_count<=flush_count+1. A flush overrides a simultaneous stall.
  - stall (no flush): every register holds; fetch_count does not increment.
  - advance: fd_instruction<=imem_data; fd_pc<=pc; fd_pc_plus1<=pc+1; fd_valid<=1; pc<=pc+1; fetch_count<=fetch_count+1.
- Latency:
  - First real instruction (mem[RESET_PC]) appears on fd_instruction at the first edge after reset deasserts with stall=0.
  - After a flush at edge E, mem[redirect_pc] loads at edge E+1, giving exactly one bubble.
- Arithmetic:
  - pc+1 is 32-bit modulo 2^32; 32'hFFFFFFFF+1 = 0.
  - Upper pc bits beyond ADDR_WIDTH are kept in pc and fd_pc but not driven to the ROM.
  - flush_count wraps modulo 2^16; fetch_count wraps modulo 2^32.
- Back-to-back flushes: each is accepted and counted. pc takes the latest redirect_pc; fd_valid stays 0.
- Reset mid-stall or mid-flush: reset wins and all outputs take reset values on that edge.
- Stall and flush are sampled only when reset=0.

Test Plan:
- Reset then run: ROM mem[i]=32'h1000_0000+i. Hold reset 2 cycles, release, stall=0 → after edge 1: fd_instruction=32'h1000_0000, fd_pc=0, fd_pc_plus1=1, fd_valid=1. After edge 3: fd_instruction=32'h1000_0002, fetch_count=3.
- Stall hold: run to fd_pc=4, stall=1 for 3 cycles → fd_instruction/fd_pc/fetch_count frozen, imem_addr=5. Release → next edge fd_pc=5, fd_instruction=32'h1000_0005.
- Flush redirect: at fd_pc=2, pulse flush with redirect_pc=40 → next edge fd_valid=0, fd_instruction=NOP, flush_count=1. Following edge fd_pc=40, fd_instruction=32'h1000_0028, fd_pc_plus1=41.
- Flush beats stall: stall=1 and flush=1 with redirect_pc=7 → next edge fd_valid=0, pc=7, flush_count incremented. Then stall=0 → fd_pc=7.
- Back-to-back flush, then reset: flush to 10 then to 20 on consecutive cycles → flush_count=2, next valid fd_pc=20. Then assert reset while stall=1 → fd_valid=0, fd_instruction=0, fetch_count=0, imem_addr=0.
- PC wrap: flush to 32'hFFFF_FFFF, run 2 advances → fd_pc=32'hFFFF_FFFF with fd_pc_plus1=0. Then fd_pc=0, imem_addr follows the low ADDR_WIDTH bits.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Signal bundle between the fetch stage, its instruction ROM, the hazard/branch
// logic that steers it, and the decode stage that consumes the F/D latch.
interface fetch_stage_if #(
   parameter int unsigned ADDR_WIDTH = 12
);

   logic                  stall;
   logic                  flush;
   logic [31:0]           redirect_pc;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [31:0]           imem_data;
   logic [31:0]           fd_instruction;
   logic [31:0]           fd_pc;
   logic [31:0]           fd_pc_plus1;
   logic                  fd_valid;
   logic [31:0]           fetch_count;
   logic [15:0]           flush_count;

   // master is the fetch stage itself; slave is everything around it
   modport master (
      input  stall, flush, redirect_pc, imem_data,
      output imem_addr, fd_instruction, fd_pc, fd_pc_plus1, fd_valid,
             fetch_count, flush_count
   );

   modport slave (
      output stall, flush, redirect_pc, imem_data,
      input  imem_addr, fd_instruction, fd_pc, fd_pc_plus1, fd_valid,
             fetch_count, flush_count
   );

endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage with PC register, synchronous-ROM address steering
// and the F/D pipeline latch feeding decode.
module fetch_stage #(
   parameter int unsigned ADDR_WIDTH = 12,
   parameter logic [31:0] RESET_PC   = 32'd0,
   parameter logic [31:0] NOP        = 32'd0
) (
   input logic           clock,
   input logic           reset,
   fetch_stage_if.master bus
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] pcPlus1;
   logic [31:0] fdInstruction_q, fdInstruction_d;
   logic [31:0] fdPc_q, fdPc_d;
   logic [31:0] fdPcPlus1_q, fdPcPlus1_d;
   logic        fdValid_q, fdValid_d;
   logic [31:0] fetchCount_q, fetchCount_d;
   logic [15:0] flushCount_q, flushCount_d;

   assign pcPlus1 = pc_q + 32'd1;

   // The ROM registers its address, so we present the PC that pc will hold
   // after this edge; that keeps imem_data equal to mem[pc] every cycle.
   always_comb begin
      bus.imem_addr = pcPlus1[ADDR_WIDTH-1:0];
      if (reset) begin
         bus.imem_addr = RESET_PC[ADDR_WIDTH-1:0];
      end else if (bus.flush) begin
         bus.imem_addr = bus.redirect_pc[ADDR_WIDTH-1:0];
      end else if (bus.stall) begin
         bus.imem_addr = pc_q[ADDR_WIDTH-1:0];
      end
   end

   always_comb begin
      pc_d            = pc_q;
      fdInstruction_d = fdInstruction_q;
      fdPc_d          = fdPc_q;
      fdPcPlus1_d     = fdPcPlus1_q;
      fdValid_d       = fdValid_q;
      fetchCount_d    = fetchCount_q;
      flushCount_d    = flushCount_q;
      if (bus.flush) begin
         pc_d            = bus.redirect_pc;
         fdInstruction_d = NOP;
         fdValid_d       = 1'b0;
         flushCount_d    = flushCount_q + 16'd1;
      end else if (!bus.stall) begin
         pc_d            = pcPlus1;
         fdInstruction_d = bus.imem_data;
         fdPc_d          = pc_q;
         fdPcPlus1_d     = pcPlus1;
         fdValid_d       = 1'b1;
         fetchCount_d    = fetchCount_q + 32'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pc_q            <= RESET_PC;
         fdInstruction_q <= NOP;
         fdPc_q          <= 32'd0;
         fdPcPlus1_q     <= 32'd0;
         fdValid_q       <= 1'b0;
         fetchCount_q    <= 32'd0;
         flushCount_q    <= 16'd0;
      end else begin
         pc_q            <= pc_d;
         fdInstruction_q <= fdInstruction_d;
         fdPc_q          <= fdPc_d;
         fdPcPlus1_q     <= fdPcPlus1_d;
         fdValid_q       <= fdValid_d;
         fetchCount_q    <= fetchCount_d;
         flushCount_q    <= flushCount_d;
      end
   end

   assign bus.fd_instruction = fdInstruction_q;
   assign bus.fd_pc          = fdPc_q;
   assign bus.fd_pc_plus1    = fdPcPlus1_q;
   assign bus.fd_valid       = fdValid_q;
   assign bus.fetch_count    = fetchCount_q;
   assign bus.flush_count    = flushCount_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table for the corner cases, then
// random stall/flush/reset traffic checked against a behavioural model.
module tb_fetch_stage;

   localparam int unsigned AW = 12;

   typedef struct {
      logic        rst;
      logic        st;
      logic        fl;
      logic [31:0] rp;
      logic [31:0] expAddr;
      logic [31:0] expInstr;
      logic [31:0] expPc;
      logic [31:0] expPlus1;
      logic        expValid;
      logic [31:0] expFetch;
      logic [15:0] expFlush;
   } vecT;

   logic clock;
   logic reset;
   int   checks;
   int   errors;

   logic [31:0] mPc;
   logic [31:0] mInstr;
   logic [31:0] mFdPc;
   logic [31:0] mPlus1;
   logic        mValid;
   logic [31:0] mFetch;
   logic [15:0] mFlush;

   vecT vecs[25];

   fetch_stage_if #(.ADDR_WIDTH(AW)) bus ();

   fetch_stage #(
      .ADDR_WIDTH(AW),
      .RESET_PC  (32'd0),
      .NOP       (32'd0)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] romWord(input logic [AW-1:0] a);
      return 32'h1000_0000 + {20'd0, a};
   endfunction

   // Synchronous ROM with one cycle of read latency
   always @(posedge clock) bus.imem_data <= romWord(bus.imem_addr);

   function automatic vecT makeVec(
      input logic rst, input logic st, input logic fl, input logic [31:0] rp,
      input logic [31:0] ea, input logic [31:0] ei, input logic [31:0] ep,
      input logic [31:0] e1, input logic ev, input logic [31:0] ef,
      input logic [15:0] efl);
      vecT v;
      v.rst = rst; v.st = st; v.fl = fl; v.rp = rp;
      v.expAddr = ea; v.expInstr = ei; v.expPc = ep; v.expPlus1 = e1;
      v.expValid = ev; v.expFetch = ef; v.expFlush = efl;
      return v;
   endfunction

   function automatic logic [31:0] modelAddr(input logic rst, input logic st,
                                             input logic fl, input logic [31:0] rp);
      logic [31:0] target;
      if (rst)      target = 32'd0;
      else if (fl)  target = rp;
      else if (st)  target = mPc;
      else          target = mPc + 32'd1;
      return {20'd0, target[AW-1:0]};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
      end
   endtask

   // The model reads mem[pc] directly instead of tracking the ROM pipeline
   task automatic updateModel(input logic rst, input logic st, input logic fl,
                              input logic [31:0] rp);
      if (rst) begin
         mPc = 32'd0; mInstr = 32'd0; mFdPc = 32'd0; mPlus1 = 32'd0;
         mValid = 1'b0; mFetch = 32'd0; mFlush = 16'd0;
      end else if (fl) begin
         mPc = rp; mInstr = 32'd0; mValid = 1'b0; mFlush = mFlush + 16'd1;
      end else if (!st) begin
         mInstr = romWord(mPc[AW-1:0]);
         mFdPc  = mPc;
         mPlus1 = mPc + 32'd1;
         mValid = 1'b1;
         mFetch = mFetch + 32'd1;
         mPc    = mPc + 32'd1;
      end
   endtask

   task automatic applyStimulus(input vecT v, input bit useTable, input string tag);
      vecT e;
      @(negedge clock);
      reset           = v.rst;
      bus.stall       = v.st;
      bus.flush       = v.fl;
      bus.redirect_pc = v.rp;
      #1;
      e = v;
      if (!useTable) e.expAddr = modelAddr(v.rst, v.st, v.fl, v.rp);
      checkOutput({tag, ".imem_addr"}, {20'd0, bus.imem_addr}, e.expAddr);
      @(posedge clock);
      updateModel(v.rst, v.st, v.fl, v.rp);
      #1;
      if (!useTable) begin
         e.expInstr = mInstr; e.expPc = mFdPc; e.expPlus1 = mPlus1;
         e.expValid = mValid; e.expFetch = mFetch; e.expFlush = mFlush;
      end
      checkOutput({tag, ".fd_instruction"}, bus.fd_instruction, e.expInstr);
      checkOutput({tag, ".fd_pc"}, bus.fd_pc, e.expPc);
      checkOutput({tag, ".fd_pc_plus1"}, bus.fd_pc_plus1, e.expPlus1);
      checkOutput({tag, ".fd_valid"}, {31'd0, bus.fd_valid}, {31'd0, e.expValid});
      checkOutput({tag, ".fetch_count"}, bus.fetch_count, e.expFetch);
      checkOutput({tag, ".flush_count"}, {16'd0, bus.flush_count}, {16'd0, e.expFlush});
   endtask

   initial begin
      vecT v;
      checks = 0;
      errors = 0;
      mPc = 32'd0; mInstr = 32'd0; mFdPc = 32'd0; mPlus1 = 32'd0;
      mValid = 1'b0; mFetch = 32'd0; mFlush = 16'd0;
      reset = 1'b1;
      bus.stall = 1'b0;
      bus.flush = 1'b0;
      bus.redirect_pc = 32'd0;

      //                rst st fl redirect        addr     instr          fd_pc          plus1      v  fetch flush
      vecs[0]  = makeVec(1, 0, 0, 32'd0,          32'd0,   32'd0,         32'd0,         32'd0,     0, 32'd0, 16'd0);
      vecs[1]  = makeVec(1, 0, 0, 32'd0,          32'd0,   32'd0,         32'd0,         32'd0,     0, 32'd0, 16'd0);
      vecs[2]  = makeVec(0, 0, 0, 32'd0,          32'd1,   32'h1000_0000, 32'd0,         32'd1,     1, 32'd1, 16'd0);
      vecs[3]  = makeVec(0, 0, 0, 32'd0,          32'd2,   32'h1000_0001, 32'd1,         32'd2,     1, 32'd2, 16'd0);
      vecs[4]  = makeVec(0, 0, 0, 32'd0,          32'd3,   32'h1000_0002, 32'd2,         32'd3,     1, 32'd3, 16'd0);
      vecs[5]  = makeVec(0, 0, 0, 32'd0,          32'd4,   32'h1000_0003, 32'd3,         32'd4,     1, 32'd4, 16'd0);
      vecs[6]  = makeVec(0, 0, 0, 32'd0,          32'd5,   32'h1000_0004, 32'd4,         32'd5,     1, 32'd5, 16'd0);
      vecs[7]  = makeVec(0, 1, 0, 32'd0,          32'd5,   32'h1000_0004, 32'd4,         32'd5,     1, 32'd5, 16'd0);
      vecs[8]  = makeVec(0, 1, 0, 32'd0,          32'd5,   32'h1000_0004, 32'd4,         32'd5,     1, 32'd5, 16'd0);
      vecs[9]  = makeVec(0, 1, 0, 32'd0,          32'd5,   32'h1000_0004, 32'd4,         32'd5,     1, 32'd5, 16'd0);
      vecs[10] = makeVec(0, 0, 0, 32'd0,          32'd6,   32'h1000_0005, 32'd5,         32'd6,     1, 32'd6, 16'd0);
      vecs[11] = makeVec(0, 0, 1, 32'd40,         32'd40,  32'd0,         32'd5,         32'd6,     0, 32'd6, 16'd1);
      vecs[12] = makeVec(0, 0, 0, 32'd0,          32'd41,  32'h1000_0028, 32'd40,        32'd41,    1, 32'd7, 16'd1);
      vecs[13] = makeVec(0, 1, 1, 32'd7,          32'd7,   32'd0,         32'd40,        32'd41,    0, 32'd7, 16'd2);
      vecs[14] = makeVec(0, 0, 0, 32'd0,          32'd8,   32'h1000_0007, 32'd7,         32'd8,     1, 32'd8, 16'd2);
      vecs[15] = makeVec(0, 0, 1, 32'd10,         32'd10,  32'd0,         32'd7,         32'd8,     0, 32'd8, 16'd3);
      vecs[16] = makeVec(0, 0, 1, 32'd20,         32'd20,  32'd0,         32'd7,         32'd8,     0, 32'd8, 16'd4);
      vecs[17] = makeVec(0, 0, 0, 32'd0,          32'd21,  32'h1000_0014, 32'd20,        32'd21,    1, 32'd9, 16'd4);
      vecs[18] = makeVec(0, 1, 0, 32'd0,          32'd21,  32'h1000_0014, 32'd20,        32'd21,    1, 32'd9, 16'd4);
      vecs[19] = makeVec(1, 1, 0, 32'd0,          32'd0,   32'd0,         32'd0,         32'd0,     0, 32'd0, 16'd0);
      vecs[20] = makeVec(0, 0, 1, 32'hFFFF_FFFF,  32'hFFF, 32'd0,         32'd0,         32'd0,     0, 32'd0, 16'd1);
      vecs[21] = makeVec(0, 0, 0, 32'd0,          32'd0,   32'h1000_0FFF, 32'hFFFF_FFFF, 32'd0,     1, 32'd1, 16'd1);
      vecs[22] = makeVec(0, 0, 0, 32'd0,          32'd1,   32'h1000_0000, 32'd0,         32'd1,     1, 32'd2, 16'd1);
      vecs[23] = makeVec(0, 0, 1, 32'h0001_2345,  32'h345, 32'd0,         32'd0,         32'd1,     0, 32'd2, 16'd2);
      vecs[24] = makeVec(0, 0, 0, 32'd0,          32'h346, 32'h1000_0345, 32'h0001_2345, 32'h0001_2346, 1, 32'd3, 16'd2);

      for (int i = 0; i < 25; i++) begin
         applyStimulus(vecs[i], 1'b1, $sformatf("vec%0d", i));
      end

      for (int i = 0; i < 1500; i++) begin
         v.rst = ($urandom_range(63) == 0);
         v.st  = ($urandom_range(3) == 0);
         v.fl  = ($urandom_range(5) == 0);
         if ($urandom_range(7) == 0) v.rp = 32'hFFFF_FFF0 | {28'd0, 4'($urandom)};
         else                        v.rp = $urandom;
         applyStimulus(v, 1'b0, $sformatf("rnd%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
